// File: rtl/vga_rx_monitor.sv
// Receive-side VGA decoder: recovers pixel position, checks sync timing, tracks lock and frame status.
// Optional build macro FRAME_CRC_EN adds a CRC-16-CCITT over each frame's visible pixels.
module vga_rx_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        HS,
  input  logic        VS,
  input  logic [3:0]  R,
  input  logic [3:0]  G,
  input  logic [3:0]  B,
  output logic        pix_valid,
  output logic [9:0]  pix_col,
  output logic [8:0]  pix_row,
  output logic [11:0] pix_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        err_pulse,
  output logic [7:0]  err_cnt,
  output logic [15:0] frame_crc
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_LAST = 10'(H_SYNC - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_BEG   = 10'(H_START);
  localparam logic [9:0] H_END   = 10'(H_START + H_ACTIVE - 1);
  localparam logic [9:0] V_BEG   = 10'(V_START);
  localparam logic [9:0] V_END   = 10'(V_START + V_ACTIVE - 1);

  typedef enum logic [1:0] {UNLOCKED, SYNCING, LOCKED} state_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      state, state_nxt;
  logic        frame_bad, bad_nxt;
  logic        hs_q, vs_q;
  logic        hs_fall, hs_rise, vs_fall;
  logic [9:0]  h_cnt, v_cnt;
  logic        armed, skip_h;
  logic        err;
  logic        visible;
  logic        done_nxt, errp_nxt;
  logic [11:0] rgb_p0;

  assign hs_fall = hs_q & ~HS;
  assign hs_rise = ~hs_q & HS;
  assign vs_fall = vs_q & ~VS;

  // Stage p0: sync sampling and position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      h_cnt  <= '0;
      v_cnt  <= '0;
      armed  <= 1'b0;
      skip_h <= 1'b0;
    end else begin
      hs_q  <= HS;
      vs_q  <= VS;
      h_cnt <= hs_fall ? 10'd0 : sat_inc10(h_cnt);
      if (vs_fall)      v_cnt <= '0;
      else if (hs_fall) v_cnt <= sat_inc10(v_cnt);
      if (vs_fall) begin
        armed  <= 1'b1;
        skip_h <= ~hs_fall;
      end else if (hs_fall) begin
        skip_h <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    rgb_p0 <= {R, G, B};
  end

  // Checks use the counters as they stood before this edge; nothing is judged until the first vs_fall.
  assign err = armed & ((hs_fall & ~vs_fall & ~skip_h & (h_cnt != H_LAST)) |
                        (hs_rise & (h_cnt != HS_LAST)) |
                        (vs_fall & (v_cnt != V_LAST)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= UNLOCKED;
      frame_bad <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_bad <= bad_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bad_nxt   = frame_bad;
    case (state)
      UNLOCKED: begin
        if (vs_fall) begin
          state_nxt = SYNCING;
          bad_nxt   = 1'b0;
        end
      end
      SYNCING: begin
        if (vs_fall) begin
          if (!frame_bad && !err) state_nxt = LOCKED;
          bad_nxt = 1'b0;
        end else if (err) begin
          bad_nxt = 1'b1;
        end
      end
      LOCKED: begin
        // The frame that lost lock cannot count as the clean frame needed to regain it
        if (err) begin
          state_nxt = SYNCING;
          bad_nxt   = 1'b1;
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  always_comb begin
    locked   = (state == LOCKED);
    done_nxt = (state == LOCKED) & vs_fall & ~err;
    errp_nxt = (state == LOCKED) & err;
  end

  // Stage p1: frame status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      err_pulse  <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      frame_done <= done_nxt;
      err_pulse  <= errp_nxt;
      if (done_nxt) frame_cnt <= frame_cnt + 16'd1;
      if (errp_nxt) err_cnt <= sat_inc8(err_cnt);
    end
  end

  assign visible   = (h_cnt >= H_BEG) && (h_cnt <= H_END) && (v_cnt >= V_BEG) && (v_cnt <= V_END);
  assign pix_valid = visible & locked;
  assign pix_col   = pix_valid ? (h_cnt - H_BEG) : '0;
  assign pix_row   = pix_valid ? 9'(v_cnt - V_BEG) : '0;
  assign pix_rgb   = pix_valid ? rgb_p0 : '0;

`ifdef FRAME_CRC_EN
  function automatic logic [15:0] crc12_step(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  logic [15:0] crc_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_run   <= 16'hFFFF;
      frame_crc <= '0;
    end else begin
      if (vs_fall)      crc_run <= 16'hFFFF;
      else if (visible) crc_run <= crc12_step(crc_run, rgb_p0);
      if (done_nxt) frame_crc <= crc_run;
    end
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor on a scaled-down raster (34x15 clocks per frame) to keep runs short.
`timescale 1ns/1ps
module tb_vga_rx_monitor;
  localparam int H_ACTIVE = 16, H_FP = 4, H_SYNC = 8, H_BP = 6;
  localparam int V_ACTIVE = 8,  V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        HS = 1'b1, VS = 1'b1;
  logic [3:0]  R = '0, G = '0, B = '0;
  logic        pix_valid, locked, frame_done, err_pulse;
  logic [9:0]  pix_col;
  logic [8:0]  pix_row;
  logic [11:0] pix_rgb;
  logic [15:0] frame_cnt, frame_crc;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int n_pv = 0, n_done = 0, n_err = 0;
  logic [11:0] cap_rgb = '0;
  bit rgb_const = 1'b0;

  vga_rx_monitor #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .HS(HS), .VS(VS), .R(R), .G(G), .B(B),
    .pix_valid(pix_valid), .pix_col(pix_col), .pix_row(pix_row), .pix_rgb(pix_rgb),
    .locked(locked), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .frame_crc(frame_crc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

`ifdef FRAME_CRC_EN
  function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) r = (r[15] ^ d[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction
  logic [15:0] m_run;
`endif

  // Reference model: positions from timestamps of the last sync edges, lock from a frame-level state.
  int t, t0, vl, st, m_col, m_row;
  bit hs_p, vs_p, armed, skip, bad, m_vis, m_done, m_err;
  logic [15:0] m_fcnt, m_crc;
  logic [7:0]  m_ecnt;
  logic [11:0] m_rgb;

  task automatic model_step();
    int  dh, h, v;
    bit  hf, hr, vf, err;
    if (!rst_n) begin
      t = 0; t0 = 0; vl = 0; st = 0;
      hs_p = 1; vs_p = 1; armed = 0; skip = 0; bad = 0;
      m_vis = 0; m_done = 0; m_err = 0; m_fcnt = 0; m_ecnt = 0; m_crc = 0; m_rgb = 0;
      m_col = 0; m_row = 0;
`ifdef FRAME_CRC_EN
      m_run = 16'hFFFF;
`endif
    end else begin
      t++;
      hf = hs_p && !HS;
      hr = !hs_p && HS;
      vf = vs_p && !VS;
      dh = t - t0;
      err = armed && ((hf && !vf && !skip && dh != H_TOTAL) ||
                      (hr && dh != H_SYNC) ||
                      (vf && vl != V_TOTAL - 1));
      m_done = 0;
      m_err = 0;
`ifdef FRAME_CRC_EN
      if (vf) begin
        if (st == 2 && !err) m_crc = m_run;
        m_run = 16'hFFFF;
      end else if (m_vis) begin
        m_run = crc_px(m_run, m_rgb);
      end
`endif
      case (st)
        0: if (vf) begin st = 1; bad = 0; end
        1: if (vf) begin if (!bad && !err) st = 2; bad = 0; end
           else if (err) bad = 1;
        2: if (err) begin
             st = 1; bad = 1; m_err = 1;
             if (m_ecnt != 8'd255) m_ecnt++;
           end else if (vf) begin
             m_done = 1; m_fcnt++;
           end
        default: ;
      endcase
      if (hf) t0 = t;
      if (vf) vl = 0; else if (hf) vl++;
      if (vf) begin armed = 1; skip = !hf; end
      else if (hf) skip = 0;
      hs_p = HS;
      vs_p = VS;
      h = (t - t0 > 1023) ? 1023 : t - t0;
      v = (vl > 1023) ? 1023 : vl;
      m_vis = (h >= H_START) && (h < H_START + H_ACTIVE) && (v >= V_START) && (v < V_START + V_ACTIVE);
      m_rgb = {R, G, B};
      m_col = h - H_START;
      m_row = v - V_START;
    end
  endtask

  always @(posedge clk) begin
    logic [74:0] exp_v, act_v;
    bit pv;
    model_step();
    #1;
    pv = m_vis && (st == 2);
    exp_v = {pv, pv ? 10'(m_col) : 10'd0, pv ? 9'(m_row) : 9'd0, pv ? m_rgb : 12'd0,
             st == 2, m_done, m_fcnt, m_err, m_ecnt, m_crc};
    act_v = {pix_valid, pix_col, pix_row, pix_rgb, locked, frame_done, frame_cnt,
             err_pulse, err_cnt, frame_crc};
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL outputs @%0t: got %h, expected %h", $time, act_v, exp_v);
    end
    if (pix_valid) n_pv++;
    if (frame_done) n_done++;
    if (err_pulse) n_err++;
    if (pix_valid && pix_col == 10'd5 && pix_row == 9'd3) cap_rgb = pix_rgb;
  end

  task automatic drive_pixels(input int L, input int p_from, input int p_to, input int hsw);
    for (int p = p_from; p <= p_to; p++) begin
      @(negedge clk);
      HS = (p >= hsw);
      VS = (L >= V_SYNC);
      if (p >= H_START && p < H_START + H_ACTIVE && L >= V_START && L < V_START + V_ACTIVE) begin
        if (rgb_const) {R, G, B} = 12'hF0F;
        else begin
          R = 4'(p - H_START);
          G = 4'(L - V_START);
          B = 4'hA;
        end
      end else begin
        {R, G, B} = 12'h000;
      end
    end
  endtask

  task automatic drive_frame(input int bad_line, input int bad_len, input int bad_hsw);
    for (int L = 0; L < V_TOTAL; L++) begin
      if (L == bad_line) drive_pixels(L, 0, bad_len - 1, bad_hsw);
      else drive_pixels(L, 0, H_TOTAL - 1, H_SYNC);
    end
  endtask

  task automatic clean_frame();
    drive_frame(-1, H_TOTAL, H_SYNC);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef FRAME_CRC_EN
    logic [15:0] crc_exp;
`endif
    repeat (5) @(posedge clk);
    #2;
    check("rst_pix", {pix_valid, pix_col, pix_row, pix_rgb}, 32'd0);
    check("rst_ctl", {locked, frame_done, err_pulse, err_cnt, frame_cnt}, 32'd0);
    check("rst_crc", frame_crc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    clean_frame(); settle();
    check("locked_after_f1", locked, 0);
    clean_frame(); settle();
    check("locked_after_f2", locked, 1);
    check("fcnt_after_f2", frame_cnt, 0);
    n_pv = 0;
    clean_frame(); settle();
    check("fcnt_after_f3", frame_cnt, 1);
    check("done_pulses_f3", n_done, 1);
    check("pix_count_f3", n_pv, 128);
    check("pix_r3c5_rgb", cap_rgb, 12'h53A);

    n_err = 0;
    drive_frame(10, H_TOTAL + 1, H_SYNC); settle();
    check("stretch_err_pulses", n_err, 1);
    check("stretch_err_cnt", err_cnt, 1);
    check("stretch_locked", locked, 0);
    check("stretch_fcnt", frame_cnt, 2);
    n_done = 0;
    clean_frame(); settle();
    check("relock1_locked", locked, 0);
    clean_frame(); settle();
    check("relock2_locked", locked, 1);
    check("relock_no_done", n_done, 0);

    drive_frame(10, H_TOTAL, H_SYNC - 1); settle();
    check("hsw_err_cnt", err_cnt, 2);
    check("hsw_locked", locked, 0);
    clean_frame(); clean_frame(); settle();
    check("hsw_relock", locked, 1);
    check("hsw_fcnt", frame_cnt, 3);

    drive_frame(10, 1100, 0); settle();
    check("nohs_err_cnt", err_cnt, 3);
    check("nohs_locked", locked, 0);
    clean_frame(); clean_frame(); settle();
    check("nohs_relock", locked, 1);
    check("nohs_fcnt", frame_cnt, 4);

    for (int L = 0; L < V_START + 3; L++) drive_pixels(L, 0, H_TOTAL - 1, H_SYNC);
    drive_pixels(V_START + 3, 0, H_START + 5, H_SYNC);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pix", {pix_valid, pix_col, pix_row, pix_rgb}, 32'd0);
    check("async_rst_ctl", {locked, frame_done, err_pulse, err_cnt, frame_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_pixels(V_START + 3, H_START + 6, H_TOTAL - 1, H_SYNC);
    for (int L = V_START + 4; L < V_TOTAL; L++) drive_pixels(L, 0, H_TOTAL - 1, H_SYNC);
    settle();
    check("postrst_fcnt", frame_cnt, 0);
    check("postrst_locked", locked, 0);
    clean_frame(); settle();
    check("postrst_sync_locked", locked, 0);
    clean_frame(); settle();
    check("postrst_relock", locked, 1);
    check("postrst_fcnt2", frame_cnt, 0);

    rgb_const = 1'b1;
    clean_frame(); clean_frame(); settle();
    check("const_fcnt", frame_cnt, 2);
    check("const_err_cnt", err_cnt, 0);
`ifdef FRAME_CRC_EN
    crc_exp = 16'hFFFF;
    for (int i = 0; i < H_ACTIVE * V_ACTIVE; i++) crc_exp = crc_px(crc_exp, 12'hF0F);
    check("const_frame_crc", frame_crc, crc_exp);
`else
    check("crc_tied_zero", frame_crc, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
